bus_transfer_ctrl: RTL

Sequencer for the shared 8-bit computer data bus: the controlling/reading end of the tri-state bus. It accepts one transfer request at a time, naming a source and a destination. It enables exactly one tri-state driver, lets the bus settle, pulses the destination's load enable, and captures the bus value. It then releases the bus with a guaranteed dead cycle before any other driver is enabled, so two drivers can never overlap on the bus.

---
 rtl/bus_transfer_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bus_transfer_ctrl.sv
// bus_transfer_ctrl
//   Sequencer for the shared tri-state data bus. It takes one transfer
//   request at a time. For each request it enables a single source driver
//   and lets the bus settle. It then strobes the destination loader while
//   capturing the bus value. Finally it releases the bus, so every transfer
//   is followed by at least one dead cycle before another driver can turn on.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   req       transfer request (level), only looked at while idle
//   src_sel   index of the driver to enable
//   dst_sel   index of the loader to strobe
//   bus_in    resolved shared bus value
//   drive_en  one-hot-or-zero tri-state output enables
//   load_en   one-hot-or-zero load strobes
//   captured  bus value latched during the last completed transfer
//   busy      high whenever a transfer is in progress
//   ack       one-cycle pulse when a transfer completes
//   err       one-cycle pulse when a request names an out-of-range index
module bus_transfer_ctrl #(
  parameter int NSRC = 4,
  parameter int NDST = 4,
  parameter int W    = 8,
  parameter int SW   = $clog2(NSRC),
  parameter int DW   = $clog2(NDST)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic [SW-1:0]   src_sel,
  input  logic [DW-1:0]   dst_sel,
  input  logic [W-1:0]    bus_in,
  output logic [NSRC-1:0] drive_en,
  output logic [NDST-1:0] load_en,
  output logic [W-1:0]    captured,
  output logic            busy,
  output logic            ack,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    LOAD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [SW-1:0]   src_q, src_next;
  logic [DW-1:0]   dst_q, dst_next;
  logic [NSRC-1:0] drive_next;
  logic [NDST-1:0] load_next;
  logic            busy_next, ack_next, err_next;
  logic            drive_active, load_active;

  // Table of which encodable select values name a real driver/loader.
  // This avoids comparisons that are constant when NSRC/NDST are powers of two.
  logic [(1<<SW)-1:0] src_ok_mask;
  logic [(1<<DW)-1:0] dst_ok_mask;
  logic               sel_ok;

  always_comb begin
    src_ok_mask = '0;
    dst_ok_mask = '0;
    for (int i = 0; i < (1 << SW); i++) src_ok_mask[i] = (i < NSRC);
    for (int i = 0; i < (1 << DW); i++) dst_ok_mask[i] = (i < NDST);
    sel_ok = src_ok_mask[src_sel] && dst_ok_mask[dst_sel];
  end

  // Next-state logic. The outputs are then decoded from the *next* state, so
  // they can be registered and still line up with the state they belong to.
  always_comb begin
    state_next = state;
    src_next   = src_q;
    dst_next   = dst_q;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (sel_ok) begin
            state_next = SETTLE;
            src_next   = src_sel;
            dst_next   = dst_sel;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      SETTLE:  state_next = LOAD;
      LOAD:    state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    drive_active = (state_next == SETTLE) || (state_next == LOAD);
    load_active  = (state_next == LOAD);
    drive_next   = '0;
    load_next    = '0;
    for (int i = 0; i < NSRC; i++) drive_next[i] = drive_active && (src_next == SW'(i));
    for (int i = 0; i < NDST; i++) load_next[i]  = load_active && (dst_next == DW'(i));
    busy_next = (state_next != IDLE);
    ack_next  = (state_next == RELEASE);
  end

  // State, latched selects and registered outputs. The asynchronous reset
  // drops every driver enable immediately, so the bus is freed without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      drive_en <= '0;
      load_en  <= '0;
      busy     <= 1'b0;
      ack      <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      src_q    <= src_next;
      dst_q    <= dst_next;
      drive_en <= drive_next;
      load_en  <= load_next;
      busy     <= busy_next;
      ack      <= ack_next;
      err      <= err_next;
    end
  end

  // The bus has settled by the LOAD cycle. Sample it on the edge leaving LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      captured <= '0;
    end else if (state == LOAD) begin
      captured <= bus_in;
    end
  end

endmodule
